rvvi_cmddec: RTL and testbench

- Parametrised host-command decoder on the tracer's Ethernet receive AXI-stream.
- Replaces the per-command single-string trigger matchers with one block that matches NUM_CMDS command headers in parallel.
- Captures a multi-word payload per command and flags malformed frames.
- Sits between the MAC's rx_axis output and the tracer control logic: ILA trigger, slow-down request, packet-rate set, and future commands.

---
 rtl/rvvi_pkg.sv | 32 +++
 rtl/rvvi_cmd_match.sv | 31 +++
 rtl/rvvi_cmddec.sv | 210 +++++++++++++++++++++
 tb/tb_rvvi_cmddec.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvvi_pkg.sv
// Purpose: shared constants, FSM state type and default command headers for the rvvi command decoder.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package rvvi_pkg;

  localparam int RVVI_HDR_WORDS = 5;
  localparam int RVVI_HDR_BITS  = 160;

  typedef enum logic [1:0] {
    HDR,
    PAY,
    DRAIN
  } rvvi_state_t;

  // Default 20-byte command headers; beat k carries bits [32k+31:32k].
  localparam logic [RVVI_HDR_BITS-1:0] RVVI_HDR_TRIGGER  = "rvvi-ila-trigger-cmd";
  localparam logic [RVVI_HDR_BITS-1:0] RVVI_HDR_SLOWDOWN = "rvvi-slowdown-req---";
  localparam logic [RVVI_HDR_BITS-1:0] RVVI_HDR_RATESET  =
    160'h6e69_6574_6172_005c_8f54_0000_1654_4502_1111_6843;

  // Selects header word idx (0..4) from a 160-bit header string.
  function automatic logic [31:0] rvvi_hdr_word(input logic [RVVI_HDR_BITS-1:0] str,
                                                input logic [2:0]               idx);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < RVVI_HDR_WORDS; k++) begin
      if (idx == 3'(k)) w = str[32*k +: 32];
    end
    return w;
  endfunction

endpackage

// File: rtl/rvvi_cmd_match.sv
// Purpose: per-command header matcher, AND-accumulating word equality across header beats.
// Latency: match is combinational for the current beat; the running result is registered per beat.
// Backpressure: none; consumes every header beat presented with beat_en.
module rvvi_cmd_match
  import rvvi_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic [RVVI_HDR_BITS-1:0] cmp_str,
  input  logic [2:0]               beat_idx,
  input  logic [31:0]              beat,
  input  logic                     beat_en,
  input  logic                     beat_full,
  output logic                     match
);

  logic acc_q;

  // Beat 0 restarts the accumulation; a partial-strobe beat kills the match.
  always_comb begin
    match = ((beat_idx == 3'd0) || acc_q) && beat_full &&
            (beat == rvvi_hdr_word(cmp_str, beat_idx));
  end

  // Sticky match bit carried from beat to beat of the header.
  always_ff @(posedge clk) begin
    if (reset)        acc_q <= 1'b0;
    else if (beat_en) acc_q <= match;
  end

endmodule

// File: rtl/rvvi_cmddec.sv
// Purpose: parallel host-command decoder on the rx AXI-stream; optional sequence check via RVVI_CMD_SEQCHK_EN.
// Latency: CmdPulse/CmdPayload update in the cycle after the accepted tlast beat.
// Backpressure: none; always ready, beats with RvviAxiRvalid=0 are ignored.
module rvvi_cmddec
  import rvvi_pkg::*;
#(
  parameter int          NUM_CMDS      = 3,
  parameter int          PAYLOAD_WORDS = 1,
  parameter logic [31:0] RESET_PAYLOAD = 32'd2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_CMDS*RVVI_HDR_BITS-1:0]   CompareStrings,
  input  logic [31:0]                         RvviAxiRdata,
  input  logic [3:0]                          RvviAxiRstrb,
  input  logic                                RvviAxiRvalid,
  input  logic                                RvviAxiRlast,
  output logic [NUM_CMDS-1:0]                 CmdPulse,
  output logic [NUM_CMDS*PAYLOAD_WORDS*32-1:0] CmdPayload,
  output logic [NUM_CMDS-1:0]                 CmdSeen,
  output logic [15:0]                         ErrCount
`ifdef RVVI_CMD_SEQCHK_EN
  ,
  output logic [15:0]                         SeqErrCount
`endif
);

  localparam logic [1:0] PAY_LAST = 2'(PAYLOAD_WORDS - 1);

  rvvi_state_t                    state_q, state_d;
  logic [2:0]                     beat_q, beat_d;
  logic [1:0]                     pay_q, pay_d;
  logic [NUM_CMDS-1:0]            win_q, win_d, win_pick, match;
  logic                           cpend_q, cpend_d;
  logic [PAYLOAD_WORDS-1:0][31:0] shadow_q, shadow_d;
  logic                           hdr_en, beat_full, commit, err_inc, seq_beat;

`ifdef RVVI_CMD_SEQCHK_EN
  logic        seq_pend_q, seq_pend_d, seq_err_inc;
  logic [15:0] exp_seq_q;
  assign seq_beat = seq_pend_q;
`else
  assign seq_beat = 1'b0;
`endif

  assign hdr_en    = RvviAxiRvalid && (state_q == HDR);
  assign beat_full = (RvviAxiRstrb == 4'hF);

  for (genvar i = 0; i < NUM_CMDS; i++) begin : g_match
    rvvi_cmd_match u_match (
      .clk       (clk),
      .reset     (reset),
      .cmp_str   (CompareStrings[i*RVVI_HDR_BITS +: RVVI_HDR_BITS]),
      .beat_idx  (beat_q),
      .beat      (RvviAxiRdata),
      .beat_en   (hdr_en),
      .beat_full (beat_full),
      .match     (match[i])
    );
  end

  // Lowest-index matching command wins when several headers match.
  always_comb begin
    logic found;
    win_pick = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_CMDS; i++) begin
      if (match[i] && !found) begin
        win_pick[i] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  // Frame walker: header match, optional sequence beat, payload capture, drain to tlast.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    pay_d    = pay_q;
    win_d    = win_q;
    cpend_d  = cpend_q;
    shadow_d = shadow_q;
    commit   = 1'b0;
    err_inc  = 1'b0;
`ifdef RVVI_CMD_SEQCHK_EN
    seq_pend_d  = seq_pend_q;
    seq_err_inc = 1'b0;
`endif
    if (RvviAxiRvalid) begin
      case (state_q)
        HDR: begin
          if (RvviAxiRlast) begin
            err_inc = |match;
          end else if (beat_q == 3'd4) begin
            beat_d = 3'd0;
            if (|match) begin
              state_d = PAY;
              win_d   = win_pick;
              pay_d   = 2'd0;
`ifdef RVVI_CMD_SEQCHK_EN
              seq_pend_d = 1'b1;
`endif
            end else begin
              state_d = DRAIN;
            end
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
        PAY: begin
          if (seq_beat) begin
`ifdef RVVI_CMD_SEQCHK_EN
            if (RvviAxiRdata[15:0] == exp_seq_q) begin
              seq_pend_d = 1'b0;
              err_inc    = RvviAxiRlast;
            end else begin
              seq_err_inc = 1'b1;
              state_d     = DRAIN;
            end
`endif
          end else begin
            for (int w = 0; w < PAYLOAD_WORDS; w++) begin
              if (pay_q == 2'(w)) shadow_d[w] = RvviAxiRdata;
            end
            if (pay_q == PAY_LAST) begin
              if (RvviAxiRlast) begin
                commit = 1'b1;
              end else begin
                state_d = DRAIN;
                cpend_d = 1'b1;
              end
            end else begin
              err_inc = RvviAxiRlast;
              pay_d   = pay_q + 2'd1;
            end
          end
        end
        DRAIN: commit = RvviAxiRlast && cpend_q;
        default: state_d = HDR;
      endcase
      // Any tlast realigns the walker to the next frame's header.
      if (RvviAxiRlast) begin
        state_d = HDR;
        beat_d  = 3'd0;
        cpend_d = 1'b0;
`ifdef RVVI_CMD_SEQCHK_EN
        seq_pend_d = 1'b0;
`endif
      end
    end
  end

  // Walker state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= HDR;
      beat_q   <= 3'd0;
      pay_q    <= 2'd0;
      win_q    <= '0;
      cpend_q  <= 1'b0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      pay_q    <= pay_d;
      win_q    <= win_d;
      cpend_q  <= cpend_d;
      shadow_q <= shadow_d;
    end
  end

  // Commit stage, independent of the walker so back-to-back frames are not stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      CmdPulse   <= '0;
      CmdSeen    <= '0;
      CmdPayload <= {(NUM_CMDS*PAYLOAD_WORDS){RESET_PAYLOAD}};
    end else begin
      CmdPulse <= commit ? win_q : '0;
      if (commit) begin
        CmdSeen <= CmdSeen | win_q;
        for (int i = 0; i < NUM_CMDS; i++) begin
          for (int w = 0; w < PAYLOAD_WORDS; w++) begin
            if (win_q[i]) CmdPayload[(i*PAYLOAD_WORDS+w)*32 +: 32] <= shadow_d[w];
          end
        end
      end
    end
  end

  // Saturating short-frame counter.
  always_ff @(posedge clk) begin
    if (reset)                                 ErrCount <= 16'd0;
    else if (err_inc && ErrCount != 16'hFFFF) ErrCount <= ErrCount + 16'd1;
  end

`ifdef RVVI_CMD_SEQCHK_EN
  // Expected sequence advances per commit; mismatches are counted, saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_seq_q   <= 16'd0;
      SeqErrCount <= 16'd0;
    end else begin
      if (commit) exp_seq_q <= exp_seq_q + 16'd1;
      if (seq_err_inc && SeqErrCount != 16'hFFFF) SeqErrCount <= SeqErrCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rvvi_cmddec.sv
// Purpose: self-checking bench for rvvi_cmddec: vector table, corner sequences, randomized frames vs model.
// Latency: checks outputs on the falling edge after each accepted tlast beat.
// Backpressure: the DUT has no ready; the bench inserts random valid-low gaps.
module tb_rvvi_cmddec;

  localparam int          NC = 3;
  localparam int          PW = 1;
  localparam logic [31:0] RP = 32'd2;
`ifdef RVVI_CMD_SEQCHK_EN
  localparam int SQ = 1;
`else
  localparam int SQ = 0;
`endif

  localparam logic [159:0] H_TRIG = "rvvi-ila-trigger-cmd";
  localparam logic [159:0] H_SLOW = "rvvi-slowdown-req---";
  localparam logic [159:0] H_RATE = 160'h6e69_6574_6172_005c_8f54_0000_1654_4502_1111_6843;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NC*160-1:0]    CompareStrings;
  logic [31:0]          RvviAxiRdata;
  logic [3:0]           RvviAxiRstrb;
  logic                 RvviAxiRvalid;
  logic                 RvviAxiRlast;
  logic [NC-1:0]        CmdPulse;
  logic [NC*PW*32-1:0]  CmdPayload;
  logic [NC-1:0]        CmdSeen;
  logic [15:0]          ErrCount;
`ifdef RVVI_CMD_SEQCHK_EN
  logic [15:0]          SeqErrCount;
`endif

  assign CompareStrings = {H_RATE, H_SLOW, H_TRIG};

  rvvi_cmddec #(.NUM_CMDS(NC), .PAYLOAD_WORDS(PW), .RESET_PAYLOAD(RP)) dut (
    .clk            (clk),
    .reset          (reset),
    .CompareStrings (CompareStrings),
    .RvviAxiRdata   (RvviAxiRdata),
    .RvviAxiRstrb   (RvviAxiRstrb),
    .RvviAxiRvalid  (RvviAxiRvalid),
    .RvviAxiRlast   (RvviAxiRlast),
    .CmdPulse       (CmdPulse),
    .CmdPayload     (CmdPayload),
    .CmdSeen        (CmdSeen),
    .ErrCount       (ErrCount)
`ifdef RVVI_CMD_SEQCHK_EN
    ,
    .SeqErrCount    (SeqErrCount)
`endif
  );

  initial forever #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Expected DUT state, owned by the bench.
  logic [NC-1:0]       e_pulse;
  logic [NC*PW*32-1:0] e_pay;
  logic [NC-1:0]       e_seen;
  logic [15:0]         e_err, e_serr, e_seq;

  logic [31:0] fd[$];
  logic [3:0]  fs[$];

  typedef struct {
    int          chan;
    int          nb;
    int          bad;
    int          sbad;
    logic [31:0] pay;
    logic [2:0]  x_pulse;
    logic [31:0] x_word;
    logic [2:0]  x_seen;
    logic [15:0] x_err;
  } vec_t;
  vec_t tv[11];

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic set_reset_expect();
    e_pulse = '0;
    e_pay   = {(NC*PW){RP}};
    e_seen  = '0;
    e_err   = 16'd0;
    e_serr  = 16'd0;
    e_seq   = 16'd0;
  endtask

  // One cycle: compare all outputs on the falling edge, then the caller drives.
  task automatic step();
    @(negedge clk);
    chk("CmdPulse",   128'(CmdPulse),   128'(e_pulse));
    chk("CmdPayload", 128'(CmdPayload), 128'(e_pay));
    chk("CmdSeen",    128'(CmdSeen),    128'(e_seen));
    chk("ErrCount",   128'(ErrCount),   128'(e_err));
`ifdef RVVI_CMD_SEQCHK_EN
    chk("SeqErrCount", 128'(SeqErrCount), 128'(e_serr));
`endif
    e_pulse = '0;
  endtask

  task automatic idle();
    step();
    RvviAxiRvalid = 1'b0;
    RvviAxiRdata  = $urandom;
    RvviAxiRstrb  = 4'($urandom);
    RvviAxiRlast  = 1'($urandom);
  endtask

  task automatic make_frame(input int chan, input int n, input int bad, input int sbad,
                            input logic [31:0] pay, input logic [15:0] seq);
    logic [31:0] w;
    fd.delete();
    fs.delete();
    for (int k = 0; k < n; k++) begin
      if (k < 5)                   w = CompareStrings[chan*160 + 32*k +: 32];
      else if (k == 5 && SQ == 1)  w = {16'hA5A5, seq};
      else if (k == 5 + SQ)        w = pay;
      else                         w = $urandom;
      if (k == bad) w = w ^ 32'h0000_0100;
      fd.push_back(w);
      fs.push_back((k == sbad) ? 4'h7 : 4'hF);
    end
  endtask

  // Whole-frame reference: classify the frame by its beats and update expectations.
  task automatic model();
    int n, cand;
    bit ok;
    n    = fd.size();
    cand = -1;
    for (int i = 0; i < NC; i++) begin
      ok = 1'b1;
      for (int k = 0; k < 5 && k < n; k++)
        if (fs[k] != 4'hF || fd[k] != CompareStrings[i*160 + 32*k +: 32]) ok = 1'b0;
      if (ok && cand < 0) cand = i;
    end
    if (cand < 0) return;
    if (SQ == 1 && n > 5 && fd[5][15:0] != e_seq) begin
      if (e_serr != 16'hFFFF) e_serr++;
      return;
    end
    if (n < 5 + SQ + PW) begin
      if (e_err != 16'hFFFF) e_err++;
      return;
    end
    for (int w = 0; w < PW; w++) e_pay[(cand*PW+w)*32 +: 32] = fd[5+SQ+w];
    e_pulse[cand] = 1'b1;
    e_seen[cand]  = 1'b1;
    if (SQ == 1) e_seq++;
  endtask

  task automatic send_frame(input bit gaps, input bit use_model);
    int n;
    n = fd.size();
    for (int k = 0; k < n; k++) begin
      if (gaps) while ($urandom_range(0, 3) == 0) idle();
      step();
      RvviAxiRdata  = fd[k];
      RvviAxiRstrb  = fs[k];
      RvviAxiRvalid = 1'b1;
      RvviAxiRlast  = (k == n - 1);
    end
    if (use_model) model();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, ch, n, bb, sb;
    logic [15:0] sq;

    tv[0]  = '{2, 6, -1, -1, 32'd77,         3'b000, 32'd2,         3'b000, 16'd0};
    tv[1]  = '{2, 6, -1, -1, 32'd40,         3'b100, 32'd40,        3'b100, 16'd0};
    tv[2]  = '{2, 5, -1, -1, 32'd0,          3'b000, 32'd40,        3'b100, 16'd1};
    tv[3]  = '{0, 6, -1, -1, 32'd7,          3'b001, 32'd7,         3'b101, 16'd1};
    tv[4]  = '{1, 6, -1,  1, 32'd11,         3'b000, 32'd2,         3'b101, 16'd1};
    tv[5]  = '{1, 8, -1, -1, 32'hDEAD_BEEF,  3'b010, 32'hDEAD_BEEF, 3'b111, 16'd1};
    tv[6]  = '{0, 3, -1, -1, 32'd0,          3'b000, 32'd7,         3'b111, 16'd2};
    tv[7]  = '{2, 1, -1, -1, 32'd0,          3'b000, 32'd40,        3'b111, 16'd3};
    tv[8]  = '{0, 3,  0, -1, 32'd0,          3'b000, 32'd7,         3'b111, 16'd3};
    tv[9]  = '{2, 4, -1,  3, 32'd0,          3'b000, 32'd40,        3'b111, 16'd3};
    tv[10] = '{0, 5,  4, -1, 32'd0,          3'b000, 32'd7,         3'b111, 16'd3};
    // Row 0 runs the rate-set frame with beat 3 altered before any commit.
    tv[0].bad = 3;

    reset         = 1'b1;
    RvviAxiRvalid = 1'b0;
    RvviAxiRdata  = '0;
    RvviAxiRstrb  = '0;
    RvviAxiRlast  = 1'b0;
    set_reset_expect();
    step();
    step();
    reset = 1'b0;
    idle();

    // Vector table: expectations are constants per row.
    for (int r = 0; r < 11; r++) begin
      nb = (tv[r].nb > 5) ? tv[r].nb + SQ : tv[r].nb;
      make_frame(tv[r].chan, nb, tv[r].bad, tv[r].sbad, tv[r].pay, e_seq);
      send_frame(1'b0, 1'b0);
      e_pulse = tv[r].x_pulse;
      e_seen  = tv[r].x_seen;
      e_err   = tv[r].x_err;
      e_pay[tv[r].chan*PW*32 +: 32] = tv[r].x_word;
      if (tv[r].x_pulse != 3'b000) e_seq++;
      idle();
      idle();
    end

    // Back-to-back frames, zero idle: pulses at T+1 and T'+1, final payload 9.
    make_frame(2, 6 + SQ, -1, -1, 32'd5, e_seq);
    send_frame(1'b0, 1'b1);
    make_frame(2, 6 + SQ, -1, -1, 32'd9, e_seq);
    send_frame(1'b0, 1'b1);
    idle();
    chk("b2b_final_payload", 128'(CmdPayload[2*PW*32 +: 32]), 128'(32'd9));

    // Reset asserted on the tlast payload beat: nothing commits.
    make_frame(2, 6 + SQ, -1, -1, 32'd123, e_seq);
    for (int k = 0; k < fd.size(); k++) begin
      step();
      RvviAxiRdata  = fd[k];
      RvviAxiRstrb  = fs[k];
      RvviAxiRvalid = 1'b1;
      RvviAxiRlast  = (k == fd.size() - 1);
      if (k == fd.size() - 1) begin
        reset = 1'b1;
        set_reset_expect();
      end
    end
    step();
    reset         = 1'b0;
    RvviAxiRvalid = 1'b0;
    idle();
    chk("rst_midframe_payload", 128'(CmdPayload[2*PW*32 +: 32]), 128'(RP));
    make_frame(2, 6 + SQ, -1, -1, 32'd55, e_seq);
    send_frame(1'b0, 1'b1);
    idle();
    chk("after_reset_decode", 128'(CmdPayload[2*PW*32 +: 32]), 128'(32'd55));

    // Randomized frames with valid gaps, checked against the frame model.
    for (int f = 0; f < 400; f++) begin
      ch = int'($urandom_range(0, NC - 1));
      n  = int'($urandom_range(1, 9));
      bb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
      sb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1;
      sq = ($urandom_range(0, 5) == 0) ? e_seq + 16'd1 : e_seq;
      make_frame(ch, n, bb, sb, $urandom, sq);
      send_frame(1'b1, 1'b1);
      if ($urandom_range(0, 2) == 0) idle();
    end
    idle();

`ifdef RVVI_CMD_SEQCHK_EN
    // Sequence numbers 0, 1, 3: third dropped; then 2 is accepted.
    step();
    reset = 1'b1;
    RvviAxiRvalid = 1'b0;
    set_reset_expect();
    step();
    reset = 1'b0;
    make_frame(0, 7, -1, -1, 32'd100, 16'd0); send_frame(1'b0, 1'b1);
    make_frame(0, 7, -1, -1, 32'd101, 16'd1); send_frame(1'b0, 1'b1);
    make_frame(0, 7, -1, -1, 32'd103, 16'd3); send_frame(1'b0, 1'b1);
    idle();
    chk("seq_err_count", 128'(SeqErrCount), 128'(16'd1));
    make_frame(0, 7, -1, -1, 32'd102, 16'd2); send_frame(1'b0, 1'b1);
    idle();
    chk("seq2_accepted", 128'(CmdPayload[31:0]), 128'(32'd102));
`endif

    // Short single-beat matching frames until ErrCount saturates, then a few more.
    for (int r = 0; r < 70000 && e_err != 16'hFFFF; r++) begin
      make_frame(0, 1, -1, -1, 32'd0, e_seq);
      send_frame(1'b0, 1'b1);
    end
    for (int r = 0; r < 4; r++) begin
      make_frame(1, 1, -1, -1, 32'd0, e_seq);
      send_frame(1'b0, 1'b1);
    end
    idle();
    chk("err_saturated", 128'(ErrCount), 128'(16'hFFFF));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
